draw_background_scroll: RTL and testbench

Parametrised VGA background generator that replaces the fixed single-screen background stage at the head of the drawing pipeline. It accepts the timing bus (counts, syncs, blanks) from the timing generator, registers it through with one cycle of latency, and produces a background colour for each pixel. It supports two frame-synchronous modes, menu and game. In game mode the road midline is dashed and scrolls horizontally at a programmable per-frame speed.

---
 rtl/draw_background_scroll.sv | 176 +++++++++++++++++
 tb/tb_draw_background_scroll.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_background_scroll.sv
// Background stage: registers the VGA timing bus and draws a menu or game background.
// Ports: clk/rst; timing bus in/out; mode_req, speed_in, pause; rgb_out, mode_out, scroll_out.
module draw_background_scroll #(
  parameter int CNT_W     = 11,
  parameter int RGB_W     = 12,
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768,
  parameter int DASH_LOG2 = 6,
  parameter int SPEED_W   = 4,
  parameter int SKY_END   = 170,
  parameter int ROAD_TOP  = 269,
  parameter int MID_TOP   = 455,
  parameter int ROAD_BOT  = 647,
  parameter int RECT_X    = 242,
  parameter int RECT_Y    = 100,
  parameter int RECT_W    = 540,
  parameter int RECT_H    = 400,
  parameter int GRASS_Y   = 630
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   hcount_in,
  input  logic [CNT_W-1:0]   vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic               mode_req,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               pause,
  output logic [CNT_W-1:0]   hcount_out,
  output logic [CNT_W-1:0]   vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               mode_out,
  output logic [CNT_W-1:0]   scroll_out
);

  localparam int CH = RGB_W / 3;

  if (RGB_W % 3 != 0 || RGB_W < 12) begin : g_err_rgb
    $error("RGB_W must be a multiple of 3 and at least 12");
  end
  if (RECT_X + RECT_W > H_ACTIVE) begin : g_err_rect
    $error("menu rectangle exceeds H_ACTIVE");
  end
  if (ROAD_BOT > V_ACTIVE) begin : g_err_road
    $error("ROAD_BOT exceeds V_ACTIVE");
  end
  if (DASH_LOG2 < 1 || DASH_LOG2 > CNT_W - 1) begin : g_err_dash
    $error("DASH_LOG2 out of range");
  end
  if (SPEED_W > CNT_W) begin : g_err_speed
    $error("SPEED_W wider than CNT_W");
  end

  // Each 4-bit channel nibble sits at the top of its channel.
  function automatic logic [RGB_W-1:0] col(input logic [11:0] c);
    logic [RGB_W-1:0] r;
    r = '0;
    r[3*CH-1 -: 4] = c[11:8];
    r[2*CH-1 -: 4] = c[7:4];
    r[CH-1 -: 4]   = c[3:0];
    return r;
  endfunction

  localparam logic [RGB_W-1:0] C_SKY   = col(12'h5CF);
  localparam logic [RGB_W-1:0] C_GRASS = col(12'h494);
  localparam logic [RGB_W-1:0] C_ROAD  = col(12'h9AB);
  localparam logic [RGB_W-1:0] C_MID   = col(12'hFF4);
  localparam logic [RGB_W-1:0] C_SIDE  = col(12'h466);
  localparam logic [RGB_W-1:0] C_MENU  = col(12'hF52);
  localparam logic [RGB_W-1:0] C_BLANK = '0;

  localparam logic [CNT_W-1:0] HA   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VA   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] RX0  = CNT_W'(RECT_X);
  localparam logic [CNT_W-1:0] RX1  = CNT_W'(RECT_X + RECT_W);
  localparam logic [CNT_W-1:0] RY0  = CNT_W'(RECT_Y);
  localparam logic [CNT_W-1:0] RY1  = CNT_W'(RECT_Y + RECT_H);
  localparam logic [CNT_W-1:0] GY   = CNT_W'(GRASS_Y);
  localparam logic [CNT_W-1:0] SKY  = CNT_W'(SKY_END);
  localparam logic [CNT_W-1:0] RT0  = CNT_W'(ROAD_TOP);
  localparam logic [CNT_W-1:0] RT1  = CNT_W'(ROAD_TOP + 6);
  localparam logic [CNT_W-1:0] MT0  = CNT_W'(MID_TOP);
  localparam logic [CNT_W-1:0] MT1  = CNT_W'(MID_TOP + 6);
  localparam logic [CNT_W-1:0] RB0  = CNT_W'(ROAD_BOT - 5);
  localparam logic [CNT_W-1:0] RB1  = CNT_W'(ROAD_BOT);

  typedef enum logic {
    MODE_MENU = 1'b0,
    MODE_GAME = 1'b1
  } mode_t;

  mode_t            mode_reg;
  logic [CNT_W-1:0] scroll;
  logic             vblnk_d;
  logic             frame_evt;
  logic [CNT_W-1:0] dash_pos;
  logic             in_rect;
  logic [RGB_W-1:0] rgb_nxt;

  assign frame_evt = vblnk_in & ~vblnk_d;
  assign dash_pos  = hcount_in + scroll;
  assign mode_out  = (mode_reg == MODE_GAME);
  assign scroll_out = scroll;

  assign in_rect = (hcount_in >= RX0) && (hcount_in < RX1)
                && (vcount_in >= RY0) && (vcount_in < RY1);

  // Pixel colour uses mode/scroll held before this cycle's
  // frame event, so a whole frame sees one setting.
  always_comb begin
    rgb_nxt = C_SIDE;
    if (hblnk_in || vblnk_in) begin
      rgb_nxt = C_BLANK;
    end else if (hcount_in >= HA || vcount_in >= VA) begin
      rgb_nxt = C_SIDE;
    end else if (mode_reg == MODE_MENU) begin
      if (in_rect)
        rgb_nxt = C_MENU;
      else if (vcount_in >= GY)
        rgb_nxt = C_GRASS;
      else
        rgb_nxt = C_SKY;
    end else begin
      if (vcount_in < SKY)
        rgb_nxt = C_SKY;
      else if (vcount_in < RT0)
        rgb_nxt = C_GRASS;
      else if (vcount_in < RT1)
        rgb_nxt = C_SIDE;
      else if (vcount_in >= MT0 && vcount_in < MT1)
        rgb_nxt = dash_pos[DASH_LOG2] ? C_ROAD : C_MID;
      else if (vcount_in >= RB0 && vcount_in < RB1)
        rgb_nxt = C_SIDE;
      else if (vcount_in >= RB1)
        rgb_nxt = C_GRASS;
      else
        rgb_nxt = C_ROAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
      mode_reg   <= MODE_MENU;
      scroll     <= '0;
      vblnk_d    <= 1'b0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_nxt;
      vblnk_d    <= vblnk_in;
      if (frame_evt) begin
        mode_reg <= mode_t'(mode_req);
        if (!pause)
          scroll <= scroll + CNT_W'(speed_in);
      end
    end
  end

endmodule

// File: tb/tb_draw_background_scroll.sv
// Directed testbench for draw_background_scroll.
// Drives single pixels and frame events, checks 1-cycle outputs.
module tb_draw_background_scroll;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        mode_req;
  logic [3:0]  speed_in;
  logic        pause;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        mode_out;
  logic [10:0] scroll_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_background_scroll dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .mode_req(mode_req), .speed_in(speed_in), .pause(pause),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .mode_out(mode_out),
    .scroll_out(scroll_out)
  );

  task automatic px(input int x, input int y,
                    input logic hb, input logic vb);
    @(negedge clk);
    hcount_in = 11'(x);
    vcount_in = 11'(y);
    hblnk_in  = hb;
    vblnk_in  = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    px(0, 0, 1'b0, 1'b0);
    px(0, 770, 1'b0, 1'b1);
    px(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    px(300, 200, 1'b0, 1'b0);
    checks++;
    if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out,
         hblnk_out, vblnk_out, mode_out, scroll_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rgb=%h h=%0d v=%0d hs=%b m=%b s=%0d exp all 0",
               rgb_out, hcount_out, vcount_out, hsync_out, mode_out, scroll_out);
    end
    rst = 1'b0;
    px(300, 200, 1'b0, 1'b0);
    checks++;
    if (hcount_out !== 11'd300 || vcount_out !== 11'd200) begin
      errors++;
      $display("FAIL pipe_counts got %0d,%0d exp 300,200", hcount_out, vcount_out);
    end
    checks++;
    if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL pipe_syncs got %b%b exp 11", hsync_out, vsync_out);
    end
    checks++;
    if (rgb_out !== 12'hF52 || mode_out !== 1'b0) begin
      errors++;
      $display("FAIL first_pixel got %h m=%b exp F52 m=0", rgb_out, mode_out);
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_menu();
    int          xs [13] = '{300, 100, 100, 241, 242, 781, 782,
                             242, 242, 100, 100, 1100, 100};
    int          ys [13] = '{200, 200, 700, 200, 100, 499, 200,
                             99, 500, 629, 630, 200, 770};
    logic [11:0] ex [13] = '{12'hF52, 12'h5CF, 12'h494, 12'h5CF,
                             12'hF52, 12'hF52, 12'h5CF, 12'h5CF,
                             12'h5CF, 12'h5CF, 12'h494, 12'h466,
                             12'h466};
    for (int i = 0; i < 13; i++) begin
      px(xs[i], ys[i], 1'b0, 1'b0);
      checks++;
      if (rgb_out !== ex[i]) begin
        errors++;
        $display("FAIL menu(%0d,%0d) got %h exp %h",
                 xs[i], ys[i], rgb_out, ex[i]);
      end
    end
    px(300, 200, 1'b1, 1'b0);
    checks++;
    if (rgb_out !== 12'h000 || hblnk_out !== 1'b1) begin
      errors++;
      $display("FAIL hblank got %h hb=%b exp 000 hb=1", rgb_out, hblnk_out);
    end
    px(300, 200, 1'b0, 1'b1);
    checks++;
    if (rgb_out !== 12'h000 || vblnk_out !== 1'b1) begin
      errors++;
      $display("FAIL vblank got %h vb=%b exp 000 vb=1", rgb_out, vblnk_out);
    end
    px(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_mode_switch();
    int          ys [14] = '{100, 300, 270, 700, 169, 170, 268,
                             274, 275, 641, 642, 646, 647, 767};
    logic [11:0] ex [14] = '{12'h5CF, 12'h9AB, 12'h466, 12'h494,
                             12'h5CF, 12'h494, 12'h494, 12'h466,
                             12'h9AB, 12'h9AB, 12'h466, 12'h466,
                             12'h494, 12'h494};
    mode_req = 1'b1;
    px(300, 200, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'hF52 || mode_out !== 1'b0) begin
      errors++;
      $display("FAIL midframe_req got %h m=%b exp F52 m=0", rgb_out, mode_out);
    end
    frame();
    mode_req = 1'b0;
    checks++;
    if (mode_out !== 1'b1) begin
      errors++;
      $display("FAIL mode_out got %b exp 1", mode_out);
    end
    for (int i = 0; i < 14; i++) begin
      px(10, ys[i], 1'b0, 1'b0);
      checks++;
      if (rgb_out !== ex[i]) begin
        errors++;
        $display("FAIL game(10,%0d) got %h exp %h", ys[i], rgb_out, ex[i]);
      end
    end
    mode_req = 1'b1;
  endtask

  task automatic test_dash();
    int          xs [9] = '{0, 63, 64, 127, 128, 0, 0, 0, 0};
    int          ys [9] = '{457, 457, 457, 457, 457, 454, 455, 460, 461};
    logic [11:0] ex [9] = '{12'hFF4, 12'hFF4, 12'h9AB, 12'h9AB,
                            12'hFF4, 12'h9AB, 12'hFF4, 12'hFF4,
                            12'h9AB};
    for (int i = 0; i < 9; i++) begin
      px(xs[i], ys[i], 1'b0, 1'b0);
      checks++;
      if (rgb_out !== ex[i]) begin
        errors++;
        $display("FAIL dash(%0d,%0d) got %h exp %h",
                 xs[i], ys[i], rgb_out, ex[i]);
      end
    end
  endtask

  task automatic test_speed();
    speed_in = 4'd5;
    for (int i = 1; i <= 3; i++) begin
      frame();
      checks++;
      if (scroll_out !== 11'(5 * i)) begin
        errors++;
        $display("FAIL scroll_f%0d got %0d exp %0d", i, scroll_out, 5 * i);
      end
    end
    px(49, 457, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'h9AB) begin
      errors++;
      $display("FAIL scrolled_h49 got %h exp 9AB", rgb_out);
    end
    px(48, 457, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'hFF4) begin
      errors++;
      $display("FAIL scrolled_h48 got %h exp FF4", rgb_out);
    end
    px(0, 0, 1'b0, 1'b0);
    repeat (3) px(0, 770, 1'b0, 1'b1);
    px(0, 0, 1'b0, 1'b0);
    checks++;
    if (scroll_out !== 11'd20) begin
      errors++;
      $display("FAIL held_vblank got %0d exp 20", scroll_out);
    end
  endtask

  task automatic test_wrap();
    speed_in = 4'd15;
    repeat (135) frame();
    speed_in = 4'd1;
    frame();
    checks++;
    if (scroll_out !== 11'd2046) begin
      errors++;
      $display("FAIL pre_wrap got %0d exp 2046", scroll_out);
    end
    speed_in = 4'd5;
    frame();
    checks++;
    if (scroll_out !== 11'd3) begin
      errors++;
      $display("FAIL wrap got %0d exp 3", scroll_out);
    end
    px(0, 457, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'hFF4) begin
      errors++;
      $display("FAIL wrap_h0 got %h exp FF4", rgb_out);
    end
    px(61, 457, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'h9AB) begin
      errors++;
      $display("FAIL wrap_h61 got %h exp 9AB", rgb_out);
    end
    pause = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame();
      checks++;
      if (scroll_out !== 11'd3) begin
        errors++;
        $display("FAIL pause_f%0d got %0d exp 3", i, scroll_out);
      end
    end
    pause = 1'b0;
    speed_in = 4'd0;
    frame();
    checks++;
    if (scroll_out !== 11'd3) begin
      errors++;
      $display("FAIL speed0 got %0d exp 3", scroll_out);
    end
  endtask

  task automatic test_reset_mid();
    hsync_in = 1'b1;
    px(500, 457, 1'b0, 1'b0);
    checks++;
    if (rgb_out !== 12'h9AB || mode_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %h m=%b exp 9AB m=1", rgb_out, mode_out);
    end
    rst = 1'b1;
    px(500, 457, 1'b0, 1'b0);
    checks++;
    if ({rgb_out, hcount_out, vcount_out, hsync_out, vsync_out,
         hblnk_out, vblnk_out, mode_out, scroll_out} !== '0) begin
      errors++;
      $display("FAIL rst_mid got rgb=%h h=%0d v=%0d hs=%b m=%b s=%0d exp all 0",
               rgb_out, hcount_out, vcount_out, hsync_out, mode_out, scroll_out);
    end
    mode_req = 1'b1;
    speed_in = 4'd7;
    px(0, 0, 1'b0, 1'b0);
    px(0, 770, 1'b0, 1'b1);
    px(0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    hsync_in = 1'b0;
    px(300, 200, 1'b0, 1'b0);
    checks++;
    if (mode_out !== 1'b0 || scroll_out !== 11'd0) begin
      errors++;
      $display("FAIL post_rst got m=%b s=%0d exp m=0 s=0", mode_out, scroll_out);
    end
    checks++;
    if (rgb_out !== 12'hF52) begin
      errors++;
      $display("FAIL post_rst_pixel got %h exp F52", rgb_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0;
    vcount_in = '0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    hblnk_in = 1'b0;
    vblnk_in = 1'b0;
    mode_req = 1'b0;
    speed_in = '0;
    pause = 1'b0;
    test_reset();
    test_menu();
    test_mode_switch();
    test_dash();
    test_speed();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
